// File: rtl/uart_rx_cfg_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cfg_fifo
// Purpose  : Configurable UART receiver with an output FIFO.
//            - 5..DATA_W_MAX data bits, optional even/odd parity, 1 or 2 stop bits.
//            - Each bit is the 3-sample majority taken around the bit centre.
//            - Completed frames are queued with their error flags and are read
//              through a valid/ready handshake.
// Ports    : CLK/RST          oversampling clock, async active-low reset
//            RX_IN            asynchronous serial line (idles high)
//            PAR_EN, PAR_TYP  parity enable / type (0 even, 1 odd)
//            STOP2, DATA_LEN  two stop bits / data bits per frame
//            Prescale         CLK cycles per bit (LSB ignored)
//            P_DATA, Parity_Error, Stop_Error   head-of-FIFO word and flags
//            data_valid/data_ready              read handshake
//            Overrun          one-cycle pulse when a completed frame is dropped
//            fifo_count       current occupancy
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_cfg_fifo #(
  parameter int DATA_W_MAX = 9,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESCALE_W = 6
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        RX_IN,
  input  logic                        PAR_EN,
  input  logic                        PAR_TYP,
  input  logic                        STOP2,
  input  logic [3:0]                  DATA_LEN,
  input  logic [PRESCALE_W-1:0]       Prescale,
  output logic [DATA_W_MAX-1:0]       P_DATA,
  output logic                        data_valid,
  input  logic                        data_ready,
  output logic                        Parity_Error,
  output logic                        Stop_Error,
  output logic                        Overrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int                    c_aw      = $clog2(FIFO_DEPTH);
  localparam int                    c_ew      = DATA_W_MAX + 2;
  localparam logic [3:0]            c_len_min = 4'd5;
  localparam logic [3:0]            c_len_max = 4'(DATA_W_MAX);
  localparam logic [PRESCALE_W-1:0] c_one     = PRESCALE_W'(1);
  localparam logic [c_aw-1:0]       c_ptr_one = c_aw'(1);
  localparam logic [c_aw:0]         c_cnt_one = (c_aw+1)'(1);
  localparam logic [c_aw:0]         c_depth   = (c_aw+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5,
    S_PUSH   = 3'd6
  } state_t;

  state_t                  r_state, w_state_n;
  logic                    r_sync1, r_sync2, r_prev, r_armed;
  logic [1:0]              r_fill;
  logic                    w_fall;
  logic                    r_par_en, r_par_typ, r_stop2;
  logic [3:0]              r_len, w_len_clamp, r_bit;
  logic [PRESCALE_W-1:0]   r_period, r_edge, w_half;
  logic                    w_last, w_s0, w_s1, w_dec, w_maj, w_bit_last;
  logic                    r_smp0, r_smp1;
  logic [DATA_W_MAX-1:0]   r_data;
  logic                    r_perr, r_serr;

  // --------------------------------------------------------------------------
  // Input synchroniser and start detection. The synchroniser resets to 1, so
  // its first two outputs after reset are not real line samples; r_fill marks
  // when they are, and r_armed only rises once the real line has been high.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_fill  <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= RX_IN;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_fill  <= {r_fill[0], 1'b1};
      if (r_fill[1] && r_sync2) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign w_fall      = r_armed & r_prev & ~r_sync2;
  assign w_len_clamp = (DATA_LEN < c_len_min) ? c_len_min :
                       (DATA_LEN > c_len_max) ? c_len_max : DATA_LEN;

  // Bit timing: r_period is always even, samples sit at half-1, half, half+1.
  assign w_half     = r_period >> 1;
  assign w_last     = (r_edge == r_period - c_one);
  assign w_s0       = (r_edge == w_half - c_one);
  assign w_s1       = (r_edge == w_half);
  assign w_dec      = (r_edge == w_half + c_one);
  assign w_maj      = (r_smp0 & r_smp1) | (r_smp0 & r_sync2) | (r_smp1 & r_sync2);
  assign w_bit_last = (r_bit == r_len - 4'd1);

  // --------------------------------------------------------------------------
  // Next-state logic. The final stop bit ends at its decision point so that a
  // start bit immediately following it is still caught from IDLE.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:   if (w_fall) w_state_n = S_START;
      S_START: begin
        if (w_dec && w_maj)  w_state_n = S_IDLE;
        else if (w_last)     w_state_n = S_DATA;
      end
      S_DATA:   if (w_last && w_bit_last) w_state_n = r_par_en ? S_PARITY : S_STOP1;
      S_PARITY: if (w_last) w_state_n = S_STOP1;
      S_STOP1: begin
        if (r_stop2) begin
          if (w_last) w_state_n = S_STOP2;
        end else if (w_dec) begin
          w_state_n = S_PUSH;
        end
      end
      S_STOP2:  if (w_dec) w_state_n = S_PUSH;
      S_PUSH:   w_state_n = S_IDLE;
      default:  w_state_n = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Receive datapath. The detection cycle already shows edge 0 of the start
  // bit on r_sync2, so the edge counter starts at 1 in START.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_edge    <= '0;
      r_bit     <= '0;
      r_period  <= '0;
      r_len     <= c_len_min;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
      r_stop2   <= 1'b0;
      r_smp0    <= 1'b1;
      r_smp1    <= 1'b1;
      r_data    <= '0;
      r_perr    <= 1'b0;
      r_serr    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (r_state == S_IDLE) begin
        r_edge <= w_fall ? c_one : '0;
        r_bit  <= '0;
        if (w_fall) begin
          r_period  <= Prescale & ~c_one;
          r_len     <= w_len_clamp;
          r_par_en  <= PAR_EN;
          r_par_typ <= PAR_TYP;
          r_stop2   <= STOP2;
          r_data    <= '0;
          r_perr    <= 1'b0;
          r_serr    <= 1'b0;
        end
      end else if (r_state == S_PUSH) begin
        r_edge <= '0;
      end else begin
        r_edge <= w_last ? '0 : r_edge + c_one;
      end

      if (w_s0) r_smp0 <= r_sync2;
      if (w_s1) r_smp1 <= r_sync2;

      if (r_state == S_DATA) begin
        if (w_dec) begin
          for (int i = 0; i < DATA_W_MAX; i++) begin
            if (r_bit == 4'(i)) r_data[i] <= w_maj;
          end
        end
        if (w_last) r_bit <= r_bit + 4'd1;
      end

      // Unused upper data bits are zero, so the full reduction XOR is exact.
      if (r_state == S_PARITY && w_dec) begin
        r_perr <= w_maj ^ (^r_data) ^ r_par_typ;
      end

      if ((r_state == S_STOP1 || r_state == S_STOP2) && w_dec && !w_maj) begin
        r_serr <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO with registered head. w_head_n is the word that will be at the
  // head after this cycle's push/pop; when the FIFO is empty after the pop,
  // the word being pushed is forwarded straight to the head register.
  // --------------------------------------------------------------------------
  logic [c_ew-1:0] r_mem [FIFO_DEPTH];
  logic [c_aw-1:0] r_wr, r_rd, w_rd_n;
  logic [c_aw:0]   r_count, w_count_n, w_left;
  logic [c_ew-1:0] w_word, w_head_n;
  logic            r_valid, w_push_req, w_pop, w_full, w_push, w_ovr;

  assign w_push_req = (r_state == S_PUSH);
  assign w_word     = {r_data, r_perr, r_serr};
  assign w_pop      = r_valid & data_ready;
  assign w_full     = (r_count == c_depth);
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovr      = w_push_req & w_full & ~w_pop;
  assign w_rd_n     = w_pop ? r_rd + c_ptr_one : r_rd;
  assign w_left     = w_pop ? r_count - c_cnt_one : r_count;

  always_comb begin
    w_count_n = r_count;
    if (w_push && !w_pop)      w_count_n = r_count + c_cnt_one;
    else if (!w_push && w_pop) w_count_n = r_count - c_cnt_one;
  end

  always_comb begin
    w_head_n = '0;
    if (w_count_n != '0) begin
      w_head_n = (w_left == '0) ? w_word : r_mem[w_rd_n];
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr] <= w_word;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr         <= '0;
      r_rd         <= '0;
      r_count      <= '0;
      r_valid      <= 1'b0;
      P_DATA       <= '0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
      Overrun      <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + c_ptr_one;
      r_rd    <= w_rd_n;
      r_count <= w_count_n;
      r_valid <= (w_count_n != '0);
      {P_DATA, Parity_Error, Stop_Error} <= w_head_n;
      Overrun <= w_ovr;
    end
  end

  assign data_valid = r_valid;
  assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_cfg_fifo
// Purpose  : Scoreboard bench for uart_rx_cfg_fifo. Frames are generated at
//            bit level from a frame description; the expected word is pushed
//            into a queue and a monitor compares on every handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg_fifo;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       STOP2 = 1'b0;
  logic [3:0] DATA_LEN = 4'd8;
  logic [5:0] Prescale = 6'd16;
  logic [8:0] P_DATA;
  logic       data_valid;
  logic       data_ready = 1'b0;
  logic       Parity_Error, Stop_Error, Overrun;
  logic [2:0] fifo_count;

  uart_rx_cfg_fifo #(.DATA_W_MAX(9), .FIFO_DEPTH(4), .PRESCALE_W(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .STOP2(STOP2), .DATA_LEN(DATA_LEN), .Prescale(Prescale), .P_DATA(P_DATA),
    .data_valid(data_valid), .data_ready(data_ready), .Parity_Error(Parity_Error),
    .Stop_Error(Stop_Error), .Overrun(Overrun), .fifo_count(fifo_count)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [10:0] exp_q[$];
  int ovr_seen = 0;
  int exp_ovr  = 0;
  int rise_cyc = 0;
  int last_run = 0;
  bit rand_ready = 1'b0;
  logic ready_req = 1'b0;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // data_ready driver
  initial forever begin
    @(posedge CLK);
    #1;
    data_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_req;
  end

  // Monitor: pops the scoreboard on every handshake, checks output hold.
  initial begin
    logic [10:0] prev_word;
    logic [10:0] got;
    logic [10:0] exp;
    bit   prev_hold;
    logic prev_valid;
    int   valid_run;
    prev_hold = 0; prev_valid = 0; valid_run = 0; prev_word = '0;
    forever begin
      @(negedge CLK);
      got = {P_DATA, Parity_Error, Stop_Error};
      if (!RST) begin
        prev_hold = 0; prev_valid = 0; valid_run = 0;
      end else begin
        if (Overrun) ovr_seen++;
        if (prev_hold) check("hold", {data_valid, got}, {1'b1, prev_word});
        if (data_valid && !prev_valid) rise_cyc = cyc;
        if (data_valid) valid_run++;
        else if (prev_valid) begin
          last_run = valid_run;
          valid_run = 0;
        end
        if (data_valid && data_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got 0x%0h, expected no word (cycle %0d)", got, cyc);
          end else begin
            exp = exp_q.pop_front();
            check("word{data,perr,serr}", got, exp);
          end
        end
        prev_hold  = data_valid && !data_ready;
        prev_word  = got;
        prev_valid = data_valid;
      end
    end
  end

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Drives one bit for p cycles; optional one-cycle inversion at the bit centre.
  task automatic bit_drive(input logic v, input int p, input bit glitch);
    int h;
    h = p / 2;
    RX_IN = v;
    if (glitch) begin
      repeat (h) @(posedge CLK);
      #1 RX_IN = ~v;
      @(posedge CLK);
      #1 RX_IN = v;
      repeat (p - h - 1) @(posedge CLK);
      #1;
    end else begin
      repeat (p) @(posedge CLK);
      #1;
    end
  endtask

  // Reference model: expected word derived from the frame description.
  task automatic send_frame(input logic [8:0] d, input logic [3:0] len, input logic pen,
                            input logic ptyp, input logic st2, input logic [5:0] ps,
                            input logic par_flip, input logic [1:0] stops, input int gbit,
                            input bit push_exp, input bit scramble);
    int n, p;
    logic [8:0] mask, dm;
    logic corr, pbit, e_pe, e_se;
    n    = (len < 5) ? 5 : (len > 9) ? 9 : int'(len);
    p    = int'(ps) & ~1;
    mask = (9'h1 << n) - 9'h1;
    dm   = d & mask;
    corr = 1'($countones(dm) % 2) ^ ptyp;
    pbit = corr ^ par_flip;
    e_pe = pen && (pbit != corr);
    e_se = !stops[0] || (st2 && !stops[1]);
    if (push_exp) exp_q.push_back({dm, e_pe, e_se});
    PAR_EN = pen; PAR_TYP = ptyp; STOP2 = st2; DATA_LEN = len; Prescale = ps;
    bit_drive(1'b0, p, 1'b0);
    if (scramble) begin
      PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom); STOP2 = 1'($urandom);
      DATA_LEN = 4'($urandom); Prescale = 6'($urandom_range(8, 63));
    end
    for (int i = 0; i < n; i++) bit_drive(dm[i], p, i == gbit);
    if (pen) bit_drive(pbit, p, 1'b0);
    bit_drive(stops[0], p, 1'b0);
    if (st2) bit_drive(stops[1], p, 1'b0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge CLK);
      t++;
    end
    #1;
    if (t >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d words pending, expected 0", exp_q.size());
    end
    idle(4);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation time limit, expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, ovr_before, gap;
    logic [1:0] stops;
    logic st2;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("reset_p_data", P_DATA, 0);
    check("reset_valid", data_valid, 0);
    check("reset_flags", {Parity_Error, Stop_Error, Overrun}, 0);
    check("reset_count", fifo_count, 0);
    RST = 1'b1;
    idle(5);

    // Reset mid-frame with a word waiting in the FIFO
    ready_req = 1'b0;
    send_frame(9'h033, 4'd8, 0, 0, 0, 6'd16, 0, 2'b11, -1, 0, 0);
    idle(4);
    check("valid_before_reset", data_valid, 1);
    RX_IN = 1'b0;
    repeat (16 + 8) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    check("midreset_p_data", P_DATA, 0);
    check("midreset_valid", data_valid, 0);
    check("midreset_flags", {Parity_Error, Stop_Error, Overrun}, 0);
    check("midreset_count", fifo_count, 0);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    repeat (40) @(posedge CLK);
    #1;
    check("low_out_of_reset_valid", data_valid, 0);
    idle(250);
    check("no_spurious_valid", data_valid, 0);
    check("no_spurious_count", fifo_count, 0);

    // 8N1 0xB2: latency and single-cycle valid
    ready_req = 1'b1;
    idle(3);
    c0 = cyc;
    send_frame(9'h0B2, 4'd8, 0, 0, 0, 6'd16, 0, 2'b11, -1, 1, 0);
    idle(5);
    n_checks++;
    if (rise_cyc <= c0 || rise_cyc - c0 > 157) begin
      n_fail++;
      $display("FAIL valid_latency: got %0d cycles, expected 1..157", rise_cyc - c0);
    end
    check("valid_width", last_run, 1);

    // 7E2 with wrong then correct parity
    send_frame(9'h05A, 4'd7, 1, 0, 1, 6'd16, 1, 2'b11, -1, 1, 0);
    idle(3);
    send_frame(9'h05A, 4'd7, 1, 0, 1, 6'd16, 0, 2'b11, -1, 1, 0);
    idle(3);

    // 9N1 with bad stop bit, then a good frame
    send_frame(9'h1A5, 4'd9, 0, 0, 0, 6'd16, 0, 2'b10, -1, 1, 0);
    idle(3);
    send_frame(9'h0F0, 4'd9, 0, 0, 0, 6'd16, 0, 2'b11, -1, 1, 0);
    drain();

    // Overrun: five back-to-back frames into a depth-4 FIFO, nobody reading
    ready_req = 1'b0;
    idle(4);
    ovr_before = ovr_seen;
    for (int k = 1; k <= 5; k++) begin
      send_frame(9'(8'h11 * k), 4'd8, 0, 0, 0, 6'd16, 0, 2'b11, -1, k <= 4, 0);
    end
    exp_ovr++;
    idle(6);
    check("overrun_count_full", fifo_count, 4);
    check("overrun_pulses", ovr_seen - ovr_before, 1);
    ready_req = 1'b1;
    drain();
    check("drained_valid", data_valid, 0);
    check("drained_count", fifo_count, 0);

    // Start-bit glitch: 4 low cycles must not produce a frame
    RX_IN = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    idle(60);
    check("glitch_start_valid", data_valid, 0);

    // Single-cycle inversions at the centre of data bit 3
    send_frame(9'h0C3, 4'd8, 0, 0, 0, 6'd16, 0, 2'b11, 3, 1, 0);
    idle(2);
    send_frame(9'h05C, 4'd8, 1, 1, 0, 6'd8, 0, 2'b11, 3, 1, 0);
    drain();

    // Randomised frames with random consumer stalls and mid-frame config churn
    rand_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      st2   = 1'($urandom);
      stops = {1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0)};
      gap   = $urandom_range(0, 4);
      if ((st2 ? stops[1] : stops[0]) == 1'b0 && gap < 2) gap = 2;
      send_frame(9'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), st2,
                 6'($urandom_range(8, 63)), 1'($urandom_range(0, 3) == 0), stops,
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : -1, 1, 1);
      idle(gap);
    end
    rand_ready = 1'b0;
    ready_req  = 1'b1;
    drain();
    check("queue_empty", exp_q.size(), 0);
    check("overrun_total", ovr_seen, exp_ovr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
